maple_packet_receiver: RTL and testbench
========================================

MAPLE_PACKET_RECEIVER -- requirements
Module: maple_packet_receiver

Interface
REQ-001 Parameter MAX_LEN, default 8'd255, maximum accepted header length field in 32-bit payload words.
REQ-002 clk  input  1  single system clock; all logic on posedge clk.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 byte_data  input  8  received byte from the Maple bus data decoder.
REQ-005 byte_ready  input  1  one-cycle pulse, byte_data valid.
REQ-006 frame_start  input  1  one-cycle pulse from the start-pattern detector.
REQ-007 frame_end  input  1  one-cycle pulse from the end-pattern detector.
REQ-008 hdr_command, hdr_dest, hdr_src, hdr_length  output  8 each  captured header fields.
REQ-009 hdr_valid  output  1  one-cycle pulse when all four header bytes have been captured.
REQ-010 word_data  output  32  assembled payload word.
REQ-011 word_valid  output  1  high while word_data holds an unconsumed word.
REQ-012 word_ready  input  1  consumer accepts the word when word_valid && word_ready.
REQ-013 frame_done  output  1  one-cycle pulse at end of frame evaluation.
REQ-014 frame_ok, err_crc, err_length, err_overflow  output  1 each  frame status; held until next frame_start or reset.

Function
REQ-015 The FSM SHALL have states IDLE, HEADER, PAYLOAD, CRC and WAIT_END.
REQ-016 IDLE: bytes and frame_end ignored; frame_start -> HEADER, clears byte counter, running XOR, and all status flags.
REQ-017 Byte order: each 32-bit word arrives least-significant byte first; header bytes 0..3 = length, src, dest, command.
REQ-018 HEADER: 4th byte -> hdr_valid pulse next cycle, with fields stable from then until the next header; length 0 -> CRC, length > MAX_LEN -> err_length=1 and WAIT_END, else -> PAYLOAD.
REQ-019 PAYLOAD: every 4th byte loads word_data and sets word_valid; after hdr_length words -> CRC.
REQ-020 word_valid clears on the cycle after word_valid && word_ready.
REQ-021 A word completing while word_valid is still high SHALL set err_overflow, discard the new word, retain the old word, and continue counting.
REQ-022 Running XOR (8-bit) covers every header and payload byte; the CRC byte SHALL equal it; a mismatch sets err_crc; the CRC byte -> WAIT_END.
REQ-023 WAIT_END: any further byte_ready sets err_length.
REQ-024 frame_end in WAIT_END: frame_done pulse and frame_ok = no error flag set; -> IDLE.
REQ-025 frame_end in HEADER, PAYLOAD or CRC: err_length=1, frame_ok=0, frame_done pulse; -> IDLE.
REQ-026 frame_start in any non-IDLE state: abort with no frame_done; restart per REQ-016.
REQ-027 frame_start and byte_ready in the same cycle: frame_start wins and the byte is dropped.
REQ-028 byte_ready and frame_end in the same cycle: the byte is processed first, then frame_end is evaluated against the post-byte state.
REQ-029 Byte and word counters SHALL be wide enough for MAX_LEN*4 + 5 bytes with no wrap-around.

Reset
REQ-030 Asynchronous assertion SHALL force IDLE and zero every output and internal register, including the hdr_* fields, word_data, word_valid, and all status flags.
REQ-031 Reset mid-frame discards the partial frame with no frame_done; reception resumes only after the next frame_start following deassertion.

Structure
REQ-032 The FSM state encodings, header byte indices and MAX_LEN default SHALL live in a shared maple_pkg package.
REQ-033 A single sub-module, maple_word_packer, SHALL assemble 4 bytes into a 32-bit word with the valid/ready holding register; all else stays flat.

Verification
REQ-034 Start; bytes 00,00,20,01; CRC 21; end -> hdr_valid with cmd=01 dest=20 src=00 len=0; frame_done, frame_ok=1.
REQ-035 Start; bytes 01,00,20,09,78,56,34,12; CRC 20; end; word_ready=1 -> one word 0x12345678; frame_ok=1.
REQ-036 Same frame as REQ-035 but CRC 22 -> err_crc=1, frame_ok=0, word 0x12345678 still delivered.
REQ-037 Header length=2, word_ready=0 throughout, 8 payload bytes -> err_overflow=1 and word_data holds the first word.
REQ-038 frame_end after 2 payload bytes -> err_length=1 and frame_done; a frame_start mid-payload -> no frame_done, and the next frame decodes OK.
REQ-039 Reset asserted mid-payload -> all outputs 0 in that cycle; the next complete frame decodes with frame_ok=1.

Source files
------------

// File: rtl/maple_pkg.sv
// Shared definitions for the Maple bus packet receiver: FSM encodings,
// header byte positions and counter sizing.
package maple_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_HEADER   = 3'd1,
    ST_PAYLOAD  = 3'd2,
    ST_CRC      = 3'd3,
    ST_WAIT_END = 3'd4
  } state_t;

  // Header bytes arrive length first, command last.
  localparam logic [1:0] HDR_IDX_LENGTH = 2'd0;
  localparam logic [1:0] HDR_IDX_SRC    = 2'd1;
  localparam logic [1:0] HDR_IDX_DEST   = 2'd2;
  localparam logic [1:0] HDR_IDX_CMD    = 2'd3;

  localparam logic [7:0] MAX_LEN_DEFAULT = 8'd255;

  // Word counter must reach the largest 8-bit length without wrapping.
  localparam int WORD_CNT_W = 9;

  // Byte counter holds a full frame: 4 header + 4*len payload + 1 CRC.
  function automatic int byte_cnt_width(input logic [7:0] max_len);
    return $clog2(int'(max_len) * 4 + 6);
  endfunction

endpackage

// File: rtl/maple_word_packer.sv
// Packs payload bytes (least-significant first) into 32-bit words and holds
// each word until the consumer takes it; words completing while full are dropped.
module maple_word_packer
  import maple_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_data,
  input  logic        word_ready,
  output logic [31:0] word_data,
  output logic        word_valid,
  output logic        word_done,
  output logic        overflow
);

  logic [1:0]  lane_reg;
  logic [23:0] assembly_reg;
  logic [31:0] word_data_reg;
  logic        word_valid_reg;

  assign word_done  = byte_en && (lane_reg == 2'd3);
  assign overflow   = word_done && word_valid_reg;
  assign word_data  = word_data_reg;
  assign word_valid = word_valid_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lane_reg       <= 2'd0;
      assembly_reg   <= 24'd0;
      word_data_reg  <= 32'd0;
      word_valid_reg <= 1'b0;
    end else begin
      if (clear) begin
        lane_reg <= 2'd0;
      end else if (byte_en) begin
        lane_reg     <= lane_reg + 2'd1;
        assembly_reg <= {byte_data, assembly_reg[23:8]};
      end
      // A held word is never overwritten; a new word only lands in an empty holder.
      if (word_done && !word_valid_reg) begin
        word_data_reg  <= {byte_data, assembly_reg};
        word_valid_reg <= 1'b1;
      end else if (word_valid_reg && word_ready) begin
        word_valid_reg <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/maple_packet_receiver.sv
// Maple bus packet receiver: header capture, payload word delivery, XOR check
// byte verification and per-frame status reporting.
module maple_packet_receiver
  import maple_pkg::*;
#(
  parameter logic [7:0] MAX_LEN = MAX_LEN_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  byte_data,
  input  logic        byte_ready,
  input  logic        frame_start,
  input  logic        frame_end,
  output logic [7:0]  hdr_command,
  output logic [7:0]  hdr_dest,
  output logic [7:0]  hdr_src,
  output logic [7:0]  hdr_length,
  output logic        hdr_valid,
  output logic [31:0] word_data,
  output logic        word_valid,
  input  logic        word_ready,
  output logic        frame_done,
  output logic        frame_ok,
  output logic        err_crc,
  output logic        err_length,
  output logic        err_overflow
);

  localparam int BYTE_CNT_W = byte_cnt_width(MAX_LEN);

  state_t                  state_reg, state_next;
  logic [BYTE_CNT_W-1:0]   byte_cnt_reg, byte_cnt_next;
  logic [WORD_CNT_W-1:0]   word_cnt_reg, word_cnt_next, word_cnt_inc;
  logic [7:0]              xor_reg, xor_next;
  logic [7:0]              shadow_len_reg, shadow_len_next;
  logic [7:0]              shadow_src_reg, shadow_src_next;
  logic [7:0]              shadow_dest_reg, shadow_dest_next;
  logic [7:0]              hdr_command_reg, hdr_command_next;
  logic [7:0]              hdr_dest_reg, hdr_dest_next;
  logic [7:0]              hdr_src_reg, hdr_src_next;
  logic [7:0]              hdr_length_reg, hdr_length_next;
  logic                    hdr_valid_reg, hdr_valid_next;
  logic                    frame_done_reg, frame_done_next;
  logic                    frame_ok_reg, frame_ok_next;
  logic                    err_crc_reg, err_crc_next;
  logic                    err_length_reg, err_length_next;
  logic                    err_overflow_reg, err_overflow_next;
  logic [1:0]              hdr_idx;
  logic                    pack_en, pack_word_done, pack_overflow;

  assign hdr_idx      = byte_cnt_reg[1:0];
  assign word_cnt_inc = word_cnt_reg + WORD_CNT_W'(1);

  maple_word_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (frame_start),
    .byte_en    (pack_en),
    .byte_data  (byte_data),
    .word_ready (word_ready),
    .word_data  (word_data),
    .word_valid (word_valid),
    .word_done  (pack_word_done),
    .overflow   (pack_overflow)
  );

  always_comb begin
    state_next        = state_reg;
    byte_cnt_next     = byte_cnt_reg;
    word_cnt_next     = word_cnt_reg;
    xor_next          = xor_reg;
    shadow_len_next   = shadow_len_reg;
    shadow_src_next   = shadow_src_reg;
    shadow_dest_next  = shadow_dest_reg;
    hdr_command_next  = hdr_command_reg;
    hdr_dest_next     = hdr_dest_reg;
    hdr_src_next      = hdr_src_reg;
    hdr_length_next   = hdr_length_reg;
    hdr_valid_next    = 1'b0;
    frame_done_next   = 1'b0;
    frame_ok_next     = frame_ok_reg;
    err_crc_next      = err_crc_reg;
    err_length_next   = err_length_reg;
    err_overflow_next = err_overflow_reg;
    pack_en           = 1'b0;

    if (frame_start) begin
      state_next        = ST_HEADER;
      byte_cnt_next     = '0;
      word_cnt_next     = '0;
      xor_next          = 8'd0;
      frame_ok_next     = 1'b0;
      err_crc_next      = 1'b0;
      err_length_next   = 1'b0;
      err_overflow_next = 1'b0;
    end else begin
      if (byte_ready) begin
        case (state_reg)
          ST_HEADER: begin
            xor_next      = xor_reg ^ byte_data;
            byte_cnt_next = byte_cnt_reg + BYTE_CNT_W'(1);
            case (hdr_idx)
              HDR_IDX_LENGTH: shadow_len_next  = byte_data;
              HDR_IDX_SRC:    shadow_src_next  = byte_data;
              HDR_IDX_DEST:   shadow_dest_next = byte_data;
              default: begin
                // Fields commit together so they never show a half-updated header.
                hdr_command_next = byte_data;
                hdr_dest_next    = shadow_dest_reg;
                hdr_src_next     = shadow_src_reg;
                hdr_length_next  = shadow_len_reg;
                hdr_valid_next   = 1'b1;
                word_cnt_next    = '0;
                if (shadow_len_reg == 8'd0) begin
                  state_next = ST_CRC;
                end else if (shadow_len_reg > MAX_LEN) begin
                  err_length_next = 1'b1;
                  state_next      = ST_WAIT_END;
                end else begin
                  state_next = ST_PAYLOAD;
                end
              end
            endcase
          end
          ST_PAYLOAD: begin
            pack_en       = 1'b1;
            xor_next      = xor_reg ^ byte_data;
            byte_cnt_next = byte_cnt_reg + BYTE_CNT_W'(1);
            if (pack_overflow) err_overflow_next = 1'b1;
            if (pack_word_done) begin
              if (word_cnt_inc == {1'b0, hdr_length_reg}) state_next = ST_CRC;
              else word_cnt_next = word_cnt_inc;
            end
          end
          ST_CRC: begin
            byte_cnt_next = byte_cnt_reg + BYTE_CNT_W'(1);
            if (byte_data != xor_reg) err_crc_next = 1'b1;
            state_next = ST_WAIT_END;
          end
          ST_WAIT_END: err_length_next = 1'b1;
          default: ;
        endcase
      end

      // frame_end sees the state after any byte taken in the same cycle.
      if (frame_end && (state_next != ST_IDLE)) begin
        frame_done_next = 1'b1;
        if (state_next == ST_WAIT_END) begin
          frame_ok_next = !(err_crc_next || err_length_next || err_overflow_next);
        end else begin
          err_length_next = 1'b1;
          frame_ok_next   = 1'b0;
        end
        state_next = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg        <= ST_IDLE;
      byte_cnt_reg     <= '0;
      word_cnt_reg     <= '0;
      xor_reg          <= 8'd0;
      shadow_len_reg   <= 8'd0;
      shadow_src_reg   <= 8'd0;
      shadow_dest_reg  <= 8'd0;
      hdr_command_reg  <= 8'd0;
      hdr_dest_reg     <= 8'd0;
      hdr_src_reg      <= 8'd0;
      hdr_length_reg   <= 8'd0;
      hdr_valid_reg    <= 1'b0;
      frame_done_reg   <= 1'b0;
      frame_ok_reg     <= 1'b0;
      err_crc_reg      <= 1'b0;
      err_length_reg   <= 1'b0;
      err_overflow_reg <= 1'b0;
    end else begin
      state_reg        <= state_next;
      byte_cnt_reg     <= byte_cnt_next;
      word_cnt_reg     <= word_cnt_next;
      xor_reg          <= xor_next;
      shadow_len_reg   <= shadow_len_next;
      shadow_src_reg   <= shadow_src_next;
      shadow_dest_reg  <= shadow_dest_next;
      hdr_command_reg  <= hdr_command_next;
      hdr_dest_reg     <= hdr_dest_next;
      hdr_src_reg      <= hdr_src_next;
      hdr_length_reg   <= hdr_length_next;
      hdr_valid_reg    <= hdr_valid_next;
      frame_done_reg   <= frame_done_next;
      frame_ok_reg     <= frame_ok_next;
      err_crc_reg      <= err_crc_next;
      err_length_reg   <= err_length_next;
      err_overflow_reg <= err_overflow_next;
    end
  end

  assign hdr_command  = hdr_command_reg;
  assign hdr_dest     = hdr_dest_reg;
  assign hdr_src      = hdr_src_reg;
  assign hdr_length   = hdr_length_reg;
  assign hdr_valid    = hdr_valid_reg;
  assign frame_done   = frame_done_reg;
  assign frame_ok     = frame_ok_reg;
  assign err_crc      = err_crc_reg;
  assign err_length   = err_length_reg;
  assign err_overflow = err_overflow_reg;

endmodule

// File: tb/tb_maple_packet_receiver.sv
// Frame-level bench: table of frames with expected header/status/words held in
// scoreboard queues, checked by a monitor as the receiver reports them.
module tb_maple_packet_receiver;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  byte_data;
  logic        byte_ready, frame_start, frame_end, word_ready;
  logic [7:0]  hdr_command, hdr_dest, hdr_src, hdr_length;
  logic        hdr_valid, word_valid, frame_done, frame_ok;
  logic        err_crc, err_length, err_overflow;
  logic [31:0] word_data;

  always #5 clk = ~clk;

  maple_packet_receiver #(.MAX_LEN(8'd4)) dut (
    .clk          (clk),
    .reset        (reset),
    .byte_data    (byte_data),
    .byte_ready   (byte_ready),
    .frame_start  (frame_start),
    .frame_end    (frame_end),
    .hdr_command  (hdr_command),
    .hdr_dest     (hdr_dest),
    .hdr_src      (hdr_src),
    .hdr_length   (hdr_length),
    .hdr_valid    (hdr_valid),
    .word_data    (word_data),
    .word_valid   (word_valid),
    .word_ready   (word_ready),
    .frame_done   (frame_done),
    .frame_ok     (frame_ok),
    .err_crc      (err_crc),
    .err_length   (err_length),
    .err_overflow (err_overflow)
  );

  typedef struct packed {
    logic [4:0]       n;         // bytes after frame_start
    logic [199:0]     b;         // first byte in the most significant used position
    logic             rdy;       // word_ready during the frame
    logic             end_last;  // frame_end together with the last byte
    logic [31:0]      hdr;       // {cmd, dest, src, len}
    logic [3:0]       flags;     // {ok, crc, len, ovf}
    logic [2:0]       nwords;
    logic [3:0][31:0] words;
  } vec_t;

  vec_t        vecs [9];
  logic [31:0] exp_hdr_q [$];
  logic [3:0]  exp_stat_q [$];
  logic [31:0] exp_word_q [$];
  logic [31:0] m_hdr, m_word;
  logic [3:0]  m_stat;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [4:0] n, input logic [199:0] b, input logic rdy,
                              input logic end_last, input logic [31:0] hdr, input logic [3:0] flags,
                              input logic [2:0] nw, input logic [127:0] words);
    vec_t v;
    v.n = n; v.b = b; v.rdy = rdy; v.end_last = end_last; v.hdr = hdr;
    v.flags = flags; v.nwords = nw; v.words = words;
    return v;
  endfunction

  // Monitor: compare every reported event against the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      if (hdr_valid) begin
        if (exp_hdr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL hdr_unexpected: got hdr_valid=1 expected none");
        end else begin
          m_hdr = exp_hdr_q.pop_front();
          chk("hdr_fields", 64'({hdr_command, hdr_dest, hdr_src, hdr_length}), 64'(m_hdr));
        end
      end
      if (frame_done) begin
        $display("frame_done ok=%b crc=%b len=%b ovf=%b", frame_ok, err_crc, err_length, err_overflow);
        if (exp_stat_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL done_unexpected: got frame_done=1 expected none");
        end else begin
          m_stat = exp_stat_q.pop_front();
          chk("frame_status", 64'({frame_ok, err_crc, err_length, err_overflow}), 64'(m_stat));
        end
      end
      if (word_valid && word_ready) begin
        $display("word %h", word_data);
        if (exp_word_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL word_unexpected: got %h expected none", word_data);
        end else begin
          m_word = exp_word_q.pop_front();
          chk("word_data", 64'(word_data), 64'(m_word));
        end
      end
    end
  end

  task automatic cyc(input logic s, input logic br, input logic [7:0] b, input logic e);
    frame_start = s; byte_ready = br; byte_data = b; frame_end = e;
    @(posedge clk); #1;
    frame_start = 1'b0; byte_ready = 1'b0; frame_end = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic apply(input vec_t v, input logic junk_on_start);
    exp_hdr_q.push_back(v.hdr);
    exp_stat_q.push_back(v.flags);
    for (int i = 0; i < int'(v.nwords); i++) exp_word_q.push_back(v.words[i]);
    word_ready = v.rdy;
    cyc(1'b1, junk_on_start, 8'hFF, 1'b0);
    for (int i = 0; i < int'(v.n); i++)
      cyc(1'b0, 1'b1, v.b[8*(int'(v.n)-1-i) +: 8], (i == int'(v.n) - 1) && v.end_last);
    if (!v.end_last) cyc(1'b0, 1'b0, 8'h00, 1'b1);
    idle(3);
    if (!v.rdy) begin
      chk("held_word", 64'({word_valid, word_data}), 64'({1'b1, v.words[0]}));
      word_ready = 1'b1;
    end
    idle(3);
  endtask

  initial begin
    vecs[0] = mk(5'd5, 200'({8'h00, 8'h00, 8'h20, 8'h01, 8'h21}), 1'b1, 1'b0,
                 32'h01200000, 4'b1000, 3'd0, 128'h0);
    vecs[1] = mk(5'd9, 200'({8'h01, 8'h00, 8'h20, 8'h09, 32'h78563412, 8'h20}), 1'b1, 1'b0,
                 32'h09200001, 4'b1000, 3'd1, 128'h12345678);
    vecs[2] = mk(5'd9, 200'({8'h01, 8'h00, 8'h20, 8'h09, 32'h78563412, 8'h22}), 1'b1, 1'b0,
                 32'h09200001, 4'b0100, 3'd1, 128'h12345678);
    vecs[3] = mk(5'd13, 200'({32'h02002009, 64'h1122334455667788, 8'hA3}), 1'b0, 1'b0,
                 32'h09200002, 4'b0001, 3'd1, 128'h44332211);
    vecs[4] = mk(5'd4, 200'({8'h05, 8'h00, 8'h20, 8'h09}), 1'b1, 1'b0,
                 32'h09200005, 4'b0010, 3'd0, 128'h0);
    vecs[5] = mk(5'd6, 200'({8'h00, 8'h00, 8'h20, 8'h01, 8'h21, 8'h55}), 1'b1, 1'b0,
                 32'h01200000, 4'b0010, 3'd0, 128'h0);
    vecs[6] = mk(5'd9, 200'({8'h01, 8'h00, 8'h20, 8'h09, 32'h78563412, 8'h20}), 1'b1, 1'b1,
                 32'h09200001, 4'b1000, 3'd1, 128'h12345678);
    vecs[7] = mk(5'd6, 200'({8'h01, 8'h00, 8'h20, 8'h09, 8'h78, 8'h56}), 1'b1, 1'b0,
                 32'h09200001, 4'b0010, 3'd0, 128'h0);
    vecs[8] = mk(5'd21, 200'({32'h04002009, 128'h000102030405060708090a0b0c0d0e0f, 8'h2D}), 1'b1, 1'b0,
                 32'h09200004, 4'b1000, 3'd4, 128'h0f0e0d0c_0b0a0908_07060504_03020100);

    reset = 1'b1; byte_data = 8'h00; byte_ready = 1'b0;
    frame_start = 1'b0; frame_end = 1'b0; word_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_hdr", 64'({hdr_command, hdr_dest, hdr_src, hdr_length, hdr_valid}), 64'(0));
    chk("reset_status", 64'({word_data, word_valid, frame_done, frame_ok, err_crc, err_length, err_overflow}), 64'(0));
    reset = 1'b0;
    idle(2);

    for (int k = 0; k < 9; k++) begin
      $display("apply vector %0d", k);
      apply(vecs[k], 1'b0);
    end

    // Restart mid-payload: no frame_done for the aborted frame.
    $display("restart mid-payload");
    exp_hdr_q.push_back(32'h09200001);
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    cyc(1'b0, 1'b1, 8'h01, 1'b0); cyc(1'b0, 1'b1, 8'h00, 1'b0);
    cyc(1'b0, 1'b1, 8'h20, 1'b0); cyc(1'b0, 1'b1, 8'h09, 1'b0);
    cyc(1'b0, 1'b1, 8'h78, 1'b0);
    apply(vecs[1], 1'b0);

    // A byte coinciding with frame_start is dropped.
    $display("byte with frame_start");
    apply(vecs[0], 1'b1);

    // Asynchronous reset mid-payload, then idle bytes/end are ignored.
    $display("reset mid-payload");
    exp_hdr_q.push_back(32'h09200001);
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    cyc(1'b0, 1'b1, 8'h01, 1'b0); cyc(1'b0, 1'b1, 8'h00, 1'b0);
    cyc(1'b0, 1'b1, 8'h20, 1'b0); cyc(1'b0, 1'b1, 8'h09, 1'b0);
    cyc(1'b0, 1'b1, 8'h78, 1'b0); cyc(1'b0, 1'b1, 8'h56, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("midreset_hdr", 64'({hdr_command, hdr_dest, hdr_src, hdr_length, hdr_valid}), 64'(0));
    chk("midreset_status", 64'({word_data, word_valid, frame_done, frame_ok, err_crc, err_length, err_overflow}), 64'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    cyc(1'b0, 1'b1, 8'h01, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    idle(3);
    apply(vecs[1], 1'b0);

    idle(5);
    chk("pending_hdr", 64'(exp_hdr_q.size()), 64'(0));
    chk("pending_status", 64'(exp_stat_q.size()), 64'(0));
    chk("pending_words", 64'(exp_word_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
